// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pkg
// Description : Shared types and constants for the IF/ID instruction queue.
//               NOP_INSTR     - encoding presented to decode when idle
//               fetch_entry_t - one queued {pc, instr} pair (32-bit fields)
//               bus_stall_e   - encoding of the two-bit bus stall input
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Field width is fixed at 32; the queue's XLEN parameter must match it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Any nonzero value freezes the queue; the individual bits identify the
  // source of the stall but are treated identically here.
  typedef enum logic [1:0] {
    STALL_NONE = 2'b00,
    STALL_IBUS = 2'b01,
    STALL_DBUS = 2'b10,
    STALL_BOTH = 2'b11
  } bus_stall_e;

endpackage
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifq_fifo
// Description : Synchronous FIFO storage for fetch entries with occupancy.
//               Ports: clk, rst (async, active-high), clear (synchronous
//               flush of pointers/count, priority over push/pop), push +
//               wr_data, pop, rd_data (combinational head), count.
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_fifo
  import if_id_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  fetch_entry_t                 wr_data,
  input  logic                         pop,
  output fetch_entry_t                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Local guards keep the FIFO from overflowing or underflowing even if a
  // caller asserts push/pop out of turn.
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Storage carries no reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : DEPTH-entry instruction queue between fetch and decode.
//               Handles decode back-pressure, bus stalls, branch flushes
//               with in-flight response dropping, and WFI bubbles.
//               Fetch side : in_valid, in_pc, in_instr -> in_ready
//               Decode side: out_ready -> out_valid, pc_ID, instr_ID
//               Control    : bus_stall, flush, wfi; status: count
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          DEPTH    = 4,
  parameter int          DROP_CNT = 1,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   bus_stall,
  input  logic                         in_valid,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [XLEN-1:0]              in_instr,
  output logic                         in_ready,
  input  logic                         out_ready,
  input  logic                         flush,
  input  logic                         wfi,
  output logic                         out_valid,
  output logic [XLEN-1:0]              pc_ID,
  output logic [XLEN-1:0]              instr_ID,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int         CW        = $clog2(DEPTH + 1);
  localparam logic [2:0] DROP_LOAD = 3'(DROP_CNT);

  logic         stalled;
  logic         accept;
  logic         push;
  logic         pop;
  logic [2:0]   drop_cnt;
  logic [31:0]  last_pc;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign stalled = (bus_stall != STALL_NONE);

  // in_ready deliberately ignores out_ready: a full queue stays closed for
  // the cycle even if decode pops, keeping the ready path short.
  assign in_ready  = (count < CW'(DEPTH)) && !stalled && !flush;
  assign out_valid = (count != '0) && !wfi && !flush;

  // Responses accepted while drop_cnt is nonzero belong to the redirected
  // stream and are swallowed instead of queued.
  assign accept = in_valid && in_ready;
  assign push   = accept && (drop_cnt == 3'd0);
  assign pop    = out_valid && out_ready && !stalled;

  assign wr_entry = '{pc: in_pc, instr: in_instr};

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .count   (count)
  );

  // Flush reloads rather than adds, so back-to-back redirects never stack
  // up more drops than responses actually in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 3'd0;
    end else if (flush) begin
      drop_cnt <= DROP_LOAD;
    end else if (accept && (drop_cnt != 3'd0)) begin
      drop_cnt <= drop_cnt - 3'd1;
    end
  end

  // Copy of the most recently consumed pc, shown while the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc <= '0;
    end else if (pop) begin
      last_pc <= head.pc;
    end
  end

  assign pc_ID    = (count != '0) ? head.pc : last_pc;
  assign instr_ID = out_valid ? head.instr : NOP;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Self-checking bench for if_id_queue (DEPTH=4, DROP_CNT=1).
//               A reference queue holds expected entries; they are pushed
//               when fetch is accepted and popped when decode consumes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;
  import if_id_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int DROP  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  bus_stall;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_ready;
  logic        flush;
  logic        wfi;
  logic        out_valid;
  logic [31:0] pc_ID;
  logic [31:0] instr_ID;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_entry_t sb[$];
  int           mdrop;
  logic [31:0]  mlast_pc;

  if_id_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .DROP_CNT (DROP),
    .NOP      (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_stall (bus_stall),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .flush     (flush),
    .wfi       (wfi),
    .out_valid (out_valid),
    .pc_ID     (pc_ID),
    .instr_ID  (instr_ID),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    case (pc)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return {pc[11:0], 20'h00093};
    endcase
  endfunction

  // Drives one cycle starting just after a rising edge, checks the
  // combinational outputs against the model, then advances both.
  task automatic cyc(input logic vld, input logic [31:0] pc, input logic ordy,
                     input logic fl, input logic w, input logic [1:0] st,
                     output logic acc);
    logic [31:0]  ins;
    int           m_cnt;
    logic         m_rdy;
    logic         m_ov;
    logic [31:0]  m_ins;
    logic [31:0]  m_pc;
    fetch_entry_t e;
    ins       = mk_instr(pc);
    in_valid  = vld;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    wfi       = w;
    bus_stall = st;
    #1;
    m_cnt = sb.size();
    m_rdy = (m_cnt < DEPTH) && (st == 2'b00) && !fl;
    m_ov  = (m_cnt != 0) && !w && !fl;
    m_ins = m_ov ? sb[0].instr : 32'h0000_0013;
    m_pc  = (m_cnt != 0) ? sb[0].pc : mlast_pc;
    check("count", 64'(count), 64'(m_cnt));
    check("in_ready", 64'(in_ready), 64'(m_rdy));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("instr_ID", 64'(instr_ID), 64'(m_ins));
    check("pc_ID", 64'(pc_ID), 64'(m_pc));
    acc = vld && m_rdy;
    if (fl) begin
      sb.delete();
      mdrop = DROP;
    end else if (st == 2'b00) begin
      if (m_ov && ordy) begin
        e = sb.pop_front();
        check("pop_entry", {pc_ID, instr_ID}, {e.pc, e.instr});
        mlast_pc = e.pc;
      end
      if (acc) begin
        if (mdrop != 0) mdrop--;
        else sb.push_back('{pc: pc, instr: ins});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, ordy, 1'b0, 1'b0, 2'b00, acc);
  endtask

  task automatic push1(input logic [31:0] pc, input logic ordy);
    logic acc;
    cyc(1'b1, pc, ordy, 1'b0, 1'b0, 2'b00, acc);
  endtask

  task automatic mid_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    wfi       = 1'b0;
    bus_stall = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_pc", 64'(pc_ID), 64'd0);
    check("rst_instr", 64'(instr_ID), 64'h13);
    check("rst_valid", 64'(out_valid), 64'd0);
    sb.delete();
    mdrop    = 0;
    mlast_pc = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic acc;
    int   idx;
    rst       = 1'b1;
    bus_stall = 2'b00;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    wfi       = 1'b0;
    mdrop     = 0;
    mlast_pc  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 64'(count), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_instr", 64'(instr_ID), 64'h13);
    check("reset_pc", 64'(pc_ID), 64'd0);
    rst = 1'b0;

    // Streaming with decode always ready: one-cycle latency, depth 1.
    push1(32'h0, 1'b1);
    push1(32'h4, 1'b1);
    push1(32'h8, 1'b1);
    idle(2, 1'b1);

    // Back-pressure: fill to DEPTH, fetch holds the fifth until space.
    idx = 0;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      cyc(1'b1, 32'(idx * 4), (c >= 6), 1'b0, 1'b0, 2'b00, acc);
      if (acc) idx++;
    end
    check("fill_progress", 64'(idx), 64'd5);
    idle(6, 1'b1);

    // Flush with three queued, one in-flight response dropped afterwards.
    push1(32'h50, 1'b0);
    push1(32'h54, 1'b0);
    push1(32'h58, 1'b0);
    cyc(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 2'b00, acc);
    push1(32'h20, 1'b1);
    push1(32'h100, 1'b1);
    idle(3, 1'b1);

    // Bus stall freezes everything, then resumes.
    push1(32'h60, 1'b0);
    push1(32'h64, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h68, 1'b1, 1'b0, 1'b0, 2'b01, acc);
    push1(32'h68, 1'b1);
    idle(4, 1'b1);

    // WFI bubbles with two queued entries.
    push1(32'h40, 1'b0);
    push1(32'h44, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00, acc);
    idle(3, 1'b1);

    // Random traffic with occasional flush, wfi and stall.
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), {$urandom_range(0, 1023), 2'b00}, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, acc);
    end

    // Asynchronous reset with three queued entries.
    for (int c = 0; c < 20 && sb.size() < 3; c++) push1(32'h300 + 32'(c * 4), 1'b0);
    check("pre_reset_fill", 64'(sb.size()), 64'd3);
    mid_reset();
    idle(1, 1'b1);

    // Reset cancels a pending drop: the next response is kept.
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'b00, acc);
    mid_reset();
    push1(32'h200, 1'b1);
    check("post_reset_kept", 64'(sb.size()), 64'd1);
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
